// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
// Control FSM feeding the output-signal decoder. Accepts one instruction word
// per valid/ready handshake, latches it into the opcode register and walks the
// execution state codes for that instruction class.
//
// Ports:
//   clk       system clock (all registers update on its rising edge)
//   rst       synchronous, active-high reset; overrides every other input
//   ir_valid  instruction word on ir is valid
//   ir        instruction word: [22:20] class, [19:16] Rx, [15:12] Ry, [11:0] imm
//   ir_ready  high while in IDLE; combinational from the state register
//   state     current state code, to decoder
//   opcode    latched instruction word, to decoder
//   alu_op    00 add, 01 sub, 10 xor, 11 and; meaningful in ARITH_A..ARITH_WB
//   done      one-cycle pulse when an instruction completes
//   illegal   one-cycle pulse when an undefined class was decoded
//   halted    high while in HALT
//   retired   wrapping count of completed instructions
//
// Handshake: a word transfers on a rising edge where ir_valid && ir_ready.
// The producer holds ir stable while ir_valid is high and not yet accepted;
// ir is ignored whenever ir_ready is low.
module ctrl_sequencer #(
  parameter int IW    = 23,
  parameter int SW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ir_valid,
  input  logic [IW-1:0]    ir,
  output logic             ir_ready,
  output logic [SW-1:0]    state,
  output logic [IW-1:0]    opcode,
  output logic [1:0]       alu_op,
  output logic             done,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [SW-1:0] {
    IDLE     = SW'(0),
    LOAD     = SW'(1),
    MOV      = SW'(2),
    ARITH_A  = SW'(3),
    ARITH_B  = SW'(4),
    ARITH_WB = SW'(5),
    DECODE   = SW'(6),
    HALT     = SW'(7)
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    opcode_q, opcode_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [2:0] op_class;
  logic [2:0] class_m2;

  assign op_class = opcode_q[IW-1 -: 3];
  // Arithmetic classes 010..101 map onto alu_op 00..11.
  assign class_m2 = op_class - 3'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      alu_op_q  <= 2'b00;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      alu_op_q  <= alu_op_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    alu_op_d  = alu_op_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    retired_d = retired_q;

    case (state_q)
      IDLE: begin
        if (ir_valid) begin
          opcode_d = ir;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        case (op_class)
          3'b000: state_d = LOAD;
          3'b001: state_d = MOV;
          3'b010, 3'b011, 3'b100, 3'b101: begin
            state_d  = ARITH_A;
            alu_op_d = class_m2[1:0];
          end
          3'b111: state_d = HALT;
          default: begin
            state_d   = IDLE;
            illegal_d = 1'b1;
          end
        endcase
      end
      // Completion: done is registered so it is high in the first IDLE cycle.
      LOAD, MOV, ARITH_WB: begin
        state_d   = IDLE;
        done_d    = 1'b1;
        retired_d = retired_q + CNT_W'(1);
      end
      ARITH_A: state_d = ARITH_B;
      ARITH_B: state_d = ARITH_WB;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign ir_ready = (state_q == IDLE);
  assign halted   = (state_q == HALT);
  assign state    = state_q;
  assign opcode   = opcode_q;
  assign alu_op   = alu_op_q;
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign retired  = retired_q;

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Control FSM directly upstream of the output-signal decoder.
- Accepts one instruction word per handshake, latches it into an opcode register and steps through the execution state codes.
- Drives the decoder's 5-bit state and 23-bit opcode inputs, plus ALU operation select, completion, error and halt flags.

Parameters:
- IW, 23, instruction/opcode width.
- SW, 5, state code width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous to clk, active-high
- ir_valid  input  1  instruction word on ir is valid
- ir  input  IW  instruction word: [22:20] class, [19:16] Rx, [15:12] Ry, [11:0] immediate
- ir_ready  output  1  sequencer can accept an instruction
- state  output  SW  state code, to decoder
- opcode  output  IW  latched instruction, to decoder
- alu_op  output  2  00 add, 01 sub, 10 xor, 11 and; valid from ARITH_A to ARITH_WB
- done  output  1  one-cycle pulse when an instruction completes
- illegal  output  1  one-cycle pulse on an undefined class
- halted  output  1  sequencer is in HALT
- retired  output  CNT_W  count of completed instructions

Behaviour:
- All registers update on rising clk only. rst has priority over every other input.
- Reset values: state=IDLE(5'b00000), opcode=0, alu_op=00, done=0, illegal=0, halted=0, retired=0. ir_ready=1 in the cycle after reset.
- Reset mid-operation abandons the instruction immediately. retired is not incremented for it.
- State codes: IDLE 00000, LOAD 00001, MOV 00010, ARITH_A 00011, ARITH_B 00100, ARITH_WB 00101, DECODE 00110, HALT 00111. The decoder treats DECODE and HALT as "no transfer".
- ir_ready = (state==IDLE). It is combinational from the state register.
- Accept: ir_valid && ir_ready on an edge. Then opcode <= ir and state <= DECODE.
- opcode holds until the next accept. ir is ignored outside IDLE.
- DECODE (1 cycle) dispatches on opcode[22:20]:
  - 000 -> LOAD
  - 001 -> MOV
  - 010/011/100/101 -> ARITH_A, with alu_op <= class-2 (010 add, 011 sub, 100 xor, 101 and)
  - 111 -> HALT
  - 110 -> IDLE, with illegal=1 for one cycle
- LOAD and MOV: 1 cycle each, then IDLE.
- ARITH_A -> ARITH_B -> ARITH_WB -> IDLE, one cycle each.
- Completion: done pulses in the cycle state returns to IDLE from LOAD, MOV or ARITH_WB. retired increments in the same edge.
- Latency from accept edge to done: LOAD/MOV 2 cycles; arithmetic 4 cycles.
- Throughput: next accept no earlier than the cycle done is high. Back-to-back LOADs retire one instruction per 3 cycles.
- retired wraps from 2^CNT_W-1 to 0 with no flag. Illegal and halt instructions are not counted.
- HALT: halted=1, ir_ready=0, and the state holds until rst.
- alu_op holds its last value outside arithmetic states.
- done and illegal are never high together.

Test Plan:
- Reset, then ir_valid=1, ir=23'h0_5_0_07B (LOAD, Rx=5) -> state 00110, 00001, 00000 on successive edges; opcode=23'h05007B; done pulses once; retired=1.
- MOV ir={3'b001,4'd3,4'd7,12'd0} -> state 00110, 00010, 00000; done after 2 cycles; opcode[19:16]=3, [15:12]=7.
- SUB ir={3'b011,4'd2,4'd4,12'd0} -> state 00110, 00011, 00100, 00101, 00000; alu_op=01 through ARITH_WB; done 4 cycles after accept.
- Class 110 -> illegal pulses 1 cycle, state back to 00000, retired unchanged. Then class 111 -> state 00111, halted=1, ir_ready=0 for 20+ cycles with ir_valid held high; rst clears all outputs.
- rst asserted during ARITH_B -> next edge state=00000, opcode=0, done=0, retired unchanged. ir_valid held during LOAD is not accepted until IDLE.
- Preload retired near 16'hFFFF via 65535 LOADs (or force), retire one more -> retired=16'h0000.
